button_conditioner: RTL and testbench
=====================================

# button_conditioner

Front-end stage for the clock/alarm set logic. Takes the three raw, bouncing, active-low push-buttons (reset, increment, mode) and produces clean control signals for the counter-select stage: a debounced active-low `RESET` level, an active-low single-cycle `INCREMENT` strobe with hold-to-repeat, and a 2-bit target selector `S` that cycles on each mode press. All outputs are registered and drive the select stage directly.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: cycles a synchronized button must hold a new level before it is accepted (10 ms at 50 MHz).
- `HOLD_CYCLES`, default 25000000: cycles increment must stay held after the first strobe before auto-repeat starts.
- `REPEAT_CYCLES`, default 5000000: auto-repeat strobe period.
- `CLK`  in  1  system clock, all logic on rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `KEY_RESET`  in  1  raw reset button, active-low, asynchronous to `CLK`.
- `KEY_INC`  in  1  raw increment button, active-low, asynchronous.
- `KEY_MODE`  in  1  raw mode button, active-low, asynchronous.
- `RESET`  out  1  debounced reset level, active-low.
- `INCREMENT`  out  1  increment strobe, active-low, exactly one cycle low per event.
- `S`  out  2  selected target: 00 clock, 01 alarm 1, 10 alarm 2, 11 alarm 3.

## Operation
- Reset values: `RESET`=1, `INCREMENT`=1, `S`=00; synchronizers and stable levels = 1 (released); all counters 0; repeat FSM in IDLE.
- Per button: 2-flop synchronizer, then debounce counter. Counter increments while synchronized level ≠ stable level and clears when they match; when mismatch persists with count = DEBOUNCE_CYCLES-1, the stable level takes the new value and the counter clears. Press event = stable level falling 1→0.
- `RESET` = registered copy of the stable reset level.
- `S`: each mode press event advances S by 1 modulo 4 (11 → 00 wraps). No other source changes S except `RST_N`.
- Increment repeat FSM, states IDLE, HOLD, REPEAT, with one shared timer:
  - IDLE: increment press event → strobe, timer cleared, go HOLD.
  - HOLD: stable increment released → IDLE; timer = HOLD_CYCLES-1 → strobe, timer cleared, go REPEAT; else timer+1.
  - REPEAT: released → IDLE; timer = REPEAT_CYCLES-1 → strobe, timer cleared; else timer+1.
- Simultaneous events:
  - Mode press event in any state forces the FSM to IDLE with no strobe that cycle; repeat does not resume until increment is released and pressed again.
  - While stable reset level is low, strobes are masked (`INCREMENT` stays 1); FSM state and timer continue normally.
- `RST_N` asserted mid-operation returns everything to reset values immediately, independent of `CLK`.
- Counter widths: $clog2 of the corresponding parameter, minimum 1 bit; no counter ever wraps.

## Timing
- Raw level changed before edge 0 and held: stable level updates on edge 2+DEBOUNCE_CYCLES; `RESET`, `S` and the first `INCREMENT` strobe update on edge 3+DEBOUNCE_CYCLES.
- Any bounce restarts the debounce count; a glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no event.
- With increment held, strobes occur at T (first), T+HOLD_CYCLES, then every REPEAT_CYCLES.
- Each strobe is low for exactly one cycle.
- Release: FSM returns to IDLE on the edge after the stable level returns to 1; no strobe is generated on release.

## Structure
- Shared package `button_pkg`: FSM state enum (IDLE, HOLD, REPEAT); selector constants SEL_CLOCK=2'b00, SEL_ALARM1=2'b01, SEL_ALARM2=2'b10, SEL_ALARM3=2'b11.
- Sub-module `debounce`: synchronizer, counter, stable level, and registered press-event output, parameterized by DEBOUNCE_CYCLES. Instantiated three times. FSM, selector and output registers live in the top.

## Test plan
Simulation parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8.
- Assert `RST_N` low with all keys pressed → `RESET`=1, `INCREMENT`=1, `S`=00 immediately, and they hold while reset is asserted.
- `KEY_INC` toggles every 2 cycles for 10 cycles, then is held low → exactly one `INCREMENT` low pulse, on edge 7 after the last transition.
- Five clean mode presses → `S` steps 01, 10, 11, 00, 01.
- Hold `KEY_INC` for 60 cycles after the first strobe at T → strobes at T, T+20, T+28, T+36, T+44, T+52, T+60; none after release.
- Hold `KEY_RESET`, then press and hold `KEY_INC` → `RESET`=0, no `INCREMENT` strobes. Release reset → `RESET` returns to 1 at edge 7 after release.
- Mode press during auto-repeat → `S` advances by 1 and strobes stop. Pulse `RST_N` during HOLD → outputs reset at once, and no strobe follows reset release while the key is still held.

Source files
------------

// File: rtl/button_pkg.sv
// button_pkg
// Shared types and constants for the button front-end.
//   rep_state_t : increment auto-repeat FSM states
//   SEL_*       : values of the 2-bit target selector S
//   KEY_*       : lane index of each button in the debounce array
//   cnt_w()     : counter width for a cycle count ($clog2, never below 1)
package button_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    localparam logic [1:0] SEL_CLOCK  = 2'b00;
    localparam logic [1:0] SEL_ALARM1 = 2'b01;
    localparam logic [1:0] SEL_ALARM2 = 2'b10;
    localparam logic [1:0] SEL_ALARM3 = 2'b11;

    localparam int NUM_KEYS  = 3;
    localparam int KEY_RST   = 0;
    localparam int KEY_INCR  = 1;
    localparam int KEY_MOD   = 2;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_conditioner_debounce.sv
// debounce
// One button lane: raw pad sample + 2-flop synchronizer, then a debounce
// counter that accepts a new level only after it has held for
// DEBOUNCE_CYCLES consecutive synchronized cycles.
//   CLK, RST_N : clock, async active-low reset
//   key        : raw active-low button, asynchronous to CLK
//   level      : debounced stable level (1 = released)
//   press      : one-cycle pulse, registered together with a 1->0 level change
module debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic key,
    output logic level,
    output logic press
);

    localparam int CW = cnt_w(DEBOUNCE_CYCLES);

    // sync[0] samples the pad, sync[2] is the metastability-safe copy used
    // by the counter; three stages place the accepted level on edge
    // 2+DEBOUNCE_CYCLES after a change seen at edge 0.
    logic [2:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync  <= '1;
            level <= 1'b1;
            press <= 1'b0;
            cnt   <= '0;
        end else begin
            sync  <= {sync[1:0], key};
            press <= 1'b0;
            if (sync[2] != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync[2];
                    press <= ~sync[2];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                // any bounce back to the stable level restarts the count
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner
// Cleans the three raw active-low buttons for the counter-select stage.
//   CLK, RST_N : clock, async active-low reset
//   KEY_RESET  : raw reset button (active-low)
//   KEY_INC    : raw increment button (active-low)
//   KEY_MODE   : raw mode button (active-low)
//   RESET      : debounced reset level, active-low, registered
//   INCREMENT  : active-low one-cycle strobe, with hold-to-repeat
//   S          : selected target, advances on each mode press (wraps 11->00)
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       KEY_RESET,
    input  logic       KEY_INC,
    input  logic       KEY_MODE,
    output logic       RESET,
    output logic       INCREMENT,
    output logic [1:0] S
);

    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = cnt_w(TMAX);

    logic [NUM_KEYS-1:0] keys;
    logic [NUM_KEYS-1:0] level;
    logic [NUM_KEYS-1:0] press;

    assign keys[KEY_RST]  = KEY_RESET;
    assign keys[KEY_INCR] = KEY_INC;
    assign keys[KEY_MOD]  = KEY_MODE;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_db
        debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .CLK   (CLK),
            .RST_N (RST_N),
            .key   (keys[g]),
            .level (level[g]),
            .press (press[g])
        );
    end

    // The reset button is consumed as a level; its press pulse has no user.
    logic unused_rst_press;
    assign unused_rst_press = press[KEY_RST];

    logic rst_lvl, inc_lvl, inc_press, mode_press;
    assign rst_lvl    = level[KEY_RST];
    assign inc_lvl    = level[KEY_INCR];
    assign inc_press  = press[KEY_INCR];
    assign mode_press = press[KEY_MOD];

    rep_state_t    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          strobe;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        strobe  = 1'b0;
        case (state_q)
            IDLE: begin
                if (inc_press) begin
                    strobe  = 1'b1;
                    timer_d = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // release wins over an expiring timer: no strobe on release
                if (inc_lvl) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == TW'(HOLD_CYCLES - 1)) begin
                    strobe  = 1'b1;
                    timer_d = '0;
                    state_d = REPEAT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REPEAT: begin
                if (inc_lvl) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == TW'(REPEAT_CYCLES - 1)) begin
                    strobe  = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
        // A mode press retargets the counters; abandon any repeat in
        // progress so a held key cannot bump the newly selected target.
        if (mode_press) begin
            strobe  = 1'b0;
            state_d = IDLE;
            timer_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RESET     <= 1'b1;
            INCREMENT <= 1'b1;
            S         <= SEL_CLOCK;
        end else begin
            RESET     <= rst_lvl;
            // strobes are masked, not the FSM, while reset is held
            INCREMENT <= ~(strobe & rst_lvl);
            if (mode_press) S <= S + 2'd1;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int HC = 20;
    localparam int RC = 8;

    logic       CLK = 1'b0;
    logic       RST_N, KEY_RESET, KEY_INC, KEY_MODE;
    logic       RESET, INCREMENT;
    logic [1:0] S;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 CLK = ~CLK;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HC),
        .REPEAT_CYCLES  (RC)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .KEY_RESET (KEY_RESET),
        .KEY_INC   (KEY_INC),
        .KEY_MODE  (KEY_MODE),
        .RESET     (RESET),
        .INCREMENT (INCREMENT),
        .S         (S)
    );

    // Inputs change and outputs are sampled on the falling edge; sample i
    // of a loop reflects rising edge i counted from the change (edge 0).

    task automatic test_reset();
        RST_N = 1'b1; KEY_RESET = 1'b1; KEY_INC = 1'b1; KEY_MODE = 1'b1;
        repeat (2) @(negedge CLK);
        RST_N = 1'b0; KEY_RESET = 1'b0; KEY_INC = 1'b0; KEY_MODE = 1'b0;
        #1;
        tests_run++; if (RESET !== 1'b1)     begin tests_failed++; $display("FAIL reset_async_RESET got %b want 1", RESET); end
        tests_run++; if (INCREMENT !== 1'b1) begin tests_failed++; $display("FAIL reset_async_INCREMENT got %b want 1", INCREMENT); end
        tests_run++; if (S !== 2'b00)        begin tests_failed++; $display("FAIL reset_async_S got %b want 00", S); end
        repeat (12) @(negedge CLK);
        tests_run++; if (RESET !== 1'b1)     begin tests_failed++; $display("FAIL reset_hold_RESET got %b want 1", RESET); end
        tests_run++; if (INCREMENT !== 1'b1) begin tests_failed++; $display("FAIL reset_hold_INCREMENT got %b want 1", INCREMENT); end
        tests_run++; if (S !== 2'b00)        begin tests_failed++; $display("FAIL reset_hold_S got %b want 00", S); end
        KEY_RESET = 1'b1; KEY_INC = 1'b1; KEY_MODE = 1'b1;
        repeat (4) @(negedge CLK);
        RST_N = 1'b1;
        repeat (10) @(negedge CLK);
    endtask

    task automatic test_glitch();
        int lows, first;
        lows = 0; first = -1;
        for (int k = 0; k < 4; k++) begin
            KEY_INC = k[0];
            repeat (2) @(negedge CLK);
        end
        KEY_INC = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (INCREMENT === 1'b0) begin
                lows++;
                if (first < 0) first = i;
            end
        end
        tests_run++; if (lows != 1)  begin tests_failed++; $display("FAIL glitch_pulse_count got %0d want 1", lows); end
        tests_run++; if (first != 7) begin tests_failed++; $display("FAIL glitch_pulse_edge got %0d want 7", first); end
        KEY_INC = 1'b1;
        lows = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            if (INCREMENT === 1'b0) lows++;
        end
        tests_run++; if (lows != 0) begin tests_failed++; $display("FAIL glitch_release_strobe got %0d want 0", lows); end
    endtask

    task automatic test_mode();
        logic [1:0] exp_s [5];
        exp_s = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
        // first press also checks the edge on which S moves
        KEY_MODE = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (i == 6) begin
                tests_run++; if (S !== 2'b00) begin tests_failed++; $display("FAIL mode_edge6 got %b want 00", S); end
            end
            if (i == 7) begin
                tests_run++; if (S !== 2'b01) begin tests_failed++; $display("FAIL mode_edge7 got %b want 01", S); end
            end
        end
        KEY_MODE = 1'b1;
        repeat (10) @(negedge CLK);
        for (int p = 1; p < 5; p++) begin
            KEY_MODE = 1'b0;
            repeat (10) @(negedge CLK);
            KEY_MODE = 1'b1;
            repeat (10) @(negedge CLK);
            tests_run++;
            if (S !== exp_s[p]) begin tests_failed++; $display("FAIL mode_press%0d got %b want %b", p + 1, S, exp_s[p]); end
        end
    endtask

    task automatic test_repeat();
        int idx [8];
        int exp_idx [7];
        int n;
        exp_idx = '{7, 27, 35, 43, 51, 59, 67};
        n = 0;
        KEY_INC = 1'b0;
        for (int i = 0; i < 110; i++) begin
            @(negedge CLK);
            if (INCREMENT === 1'b0) begin
                if (n < 8) idx[n] = i;
                n++;
            end
            if (i == 67) KEY_INC = 1'b1;
        end
        tests_run++; if (n != 7) begin tests_failed++; $display("FAIL repeat_count got %0d want 7", n); end
        for (int k = 0; k < 7; k++) begin
            if (k < n) begin
                tests_run++;
                if (idx[k] != exp_idx[k]) begin tests_failed++; $display("FAIL repeat_strobe%0d got edge %0d want %0d", k, idx[k], exp_idx[k]); end
            end
        end
        tests_run++; if (S !== 2'b01) begin tests_failed++; $display("FAIL repeat_S_unchanged got %b want 01", S); end
    endtask

    task automatic test_reset_mask();
        int lows;
        KEY_RESET = 1'b0;
        repeat (10) @(negedge CLK);
        tests_run++; if (RESET !== 1'b0) begin tests_failed++; $display("FAIL mask_RESET_low got %b want 0", RESET); end
        KEY_INC = 1'b0;
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (INCREMENT === 1'b0) lows++;
        end
        KEY_INC = 1'b1;
        repeat (15) @(negedge CLK);
        tests_run++; if (lows != 0) begin tests_failed++; $display("FAIL mask_strobes got %0d want 0", lows); end
        KEY_RESET = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (i == 6) begin
                tests_run++; if (RESET !== 1'b0) begin tests_failed++; $display("FAIL mask_release_edge6 got %b want 0", RESET); end
            end
            if (i == 7) begin
                tests_run++; if (RESET !== 1'b1) begin tests_failed++; $display("FAIL mask_release_edge7 got %b want 1", RESET); end
            end
        end
    endtask

    task automatic test_mode_during_repeat();
        int late;
        late = 0;
        KEY_INC = 1'b0;
        for (int i = 0; i < 90; i++) begin
            @(negedge CLK);
            if (i >= 44 && INCREMENT === 1'b0) late++;
            if (i == 44) begin
                tests_run++; if (S !== 2'b01) begin tests_failed++; $display("FAIL mrep_S_before got %b want 01", S); end
            end
            if (i == 45) begin
                tests_run++; if (S !== 2'b10) begin tests_failed++; $display("FAIL mrep_S_after got %b want 10", S); end
            end
            if (i == 37) KEY_MODE = 1'b0;
        end
        tests_run++; if (late != 0) begin tests_failed++; $display("FAIL mrep_strobes_after_mode got %0d want 0", late); end
        KEY_INC = 1'b1; KEY_MODE = 1'b1;
        repeat (15) @(negedge CLK);
        tests_run++; if (S !== 2'b10) begin tests_failed++; $display("FAIL mrep_S_final got %b want 10", S); end
    endtask

    task automatic test_rstn_in_hold();
        int lows;
        KEY_INC = 1'b0;
        repeat (16) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        tests_run++; if (S !== 2'b00)        begin tests_failed++; $display("FAIL rstn_S got %b want 00", S); end
        tests_run++; if (INCREMENT !== 1'b1) begin tests_failed++; $display("FAIL rstn_INCREMENT got %b want 1", INCREMENT); end
        tests_run++; if (RESET !== 1'b1)     begin tests_failed++; $display("FAIL rstn_RESET got %b want 1", RESET); end
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        lows = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge CLK);
            if (INCREMENT === 1'b0) lows++;
            // key is let go before its debounce can complete
            if (i == 1) KEY_INC = 1'b1;
        end
        tests_run++; if (lows != 0) begin tests_failed++; $display("FAIL rstn_no_strobe got %0d want 0", lows); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_mode();
        test_repeat();
        test_reset_mask();
        test_mode_during_repeat();
        test_rstn_in_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
